// File: rtl/mul_pkg.sv
// mul_pkg: state encoding and sizing shared by the iterative multiplier and its Wallace row.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int STEP = 8;
  localparam int CCW = 6;
  function automatic int calc_cycles(input int w);
    return w / STEP;
  endfunction
endpackage

// File: rtl/mul_wallace_row.sv
// mul_wallace_row: unsigned W x 8 product; one full-adder column slice per output bit
// passes 6 carries to the next column, leaving two rows for a final carry-propagate add.
module mul_wallace_row
  import mul_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]      i_a,
  input  logic [STEP-1:0]   i_b,
  output logic [W+STEP-1:0] o_p
);
  localparam int N = W + STEP;
  logic [N-1:0] w_pp [STEP];
  logic [CCW-1:0] w_c [N];
  logic [N-1:0] w_x, w_y;
  for (genvar k = 0; k < STEP; k++) begin : g_pp
    assign w_pp[k] = (N'(i_a) << k) & {N{i_b[k]}};
  end
  for (genvar j = 0; j < N; j++) begin : g_col
    logic [CCW-1:0] w_ci, w_co;
    logic [STEP+CCW-1:0] w_v;
    logic w_t;
    if (j == 0) begin : g_lsb
      assign w_ci = '0;
    end else begin : g_mid
      assign w_ci = w_c[j-1];
    end
    // 14 inputs reduced by a chain of 6 full adders to 2 bits plus 6 carries
    always_comb begin
      for (int k = 0; k < STEP; k++) w_v[k] = w_pp[k][j];
      w_v[STEP+CCW-1:STEP] = w_ci;
      w_t = w_v[0];
      for (int k = 0; k < CCW; k++) begin
        w_co[k] = (w_t & w_v[2*k+1]) | (w_t & w_v[2*k+2]) | (w_v[2*k+1] & w_v[2*k+2]);
        w_t = w_t ^ w_v[2*k+1] ^ w_v[2*k+2];
      end
    end
    assign w_c[j] = w_co;
    assign w_x[j] = w_t;
    assign w_y[j] = w_v[STEP+CCW-1];
  end
  assign o_p = w_x + w_y;
endmodule

// File: rtl/mul_iter_wallace_ctrl.sv
// mul_iter_wallace_ctrl: W x W multiplier time-sharing one Wallace row over W/8 cycles.
// Define MUL_EARLY_TERM_EN to leave CALC once the remaining multiplier bits are all zero.
module mul_iter_wallace_ctrl
  import mul_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic           i_signed,
  input  logic [W-1:0]   i_num_a,
  input  logic [W-1:0]   i_num_b,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [2*W-1:0] o_res,
  output logic           o_busy
);
  localparam int NCYC = calc_cycles(W);
  localparam int CW = $clog2(NCYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);
  state_t r_state;
  logic [W-1:0] r_a, r_mb;
  logic [2*W-1:0] r_acc, r_res;
  logic [CW-1:0] r_cnt;
  logic r_neg, r_valid;
  logic [W+STEP-1:0] w_row;
  logic [2*W-1:0] w_add;
  logic [W-1:0] w_mb_nxt;
  logic w_last;
  mul_wallace_row #(.W(W)) u_row (.i_a(r_a), .i_b(r_mb[STEP-1:0]), .o_p(w_row));
  assign w_add = (2*W)'(w_row) << {r_cnt, 3'b000};
  assign w_mb_nxt = r_mb >> STEP;
`ifdef MUL_EARLY_TERM_EN
  assign w_last = (r_cnt == LAST) || (w_mb_nxt == '0);
`else
  assign w_last = r_cnt == LAST;
`endif
  assign o_ready = r_state == IDLE;
  assign o_busy = r_state != IDLE;
  assign o_valid = r_valid;
  assign o_res = r_res;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_mb <= '0;
      r_acc <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_valid <= 1'b0;
    end else
      case (r_state)
        IDLE: if (i_valid) begin
          r_a <= (i_signed && i_num_a[W-1]) ? -i_num_a : i_num_a;
          r_mb <= (i_signed && i_num_b[W-1]) ? -i_num_b : i_num_b;
          r_neg <= i_signed & (i_num_a[W-1] ^ i_num_b[W-1]);
          r_acc <= '0;
          r_cnt <= '0;
          r_state <= CALC;
        end
        CALC: begin
          r_acc <= r_acc + w_add;
          r_mb <= w_mb_nxt;
          r_cnt <= r_cnt + 1'b1;
          r_state <= w_last ? FIX : CALC;
        end
        FIX: begin
          r_res <= r_neg ? -r_acc : r_acc;
          r_state <= DONE;
        end
        default: if (!r_valid) r_valid <= 1'b1;
          else if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_mul_iter_wallace_ctrl.sv
// tb_mul_iter_wallace_ctrl: directed and random checks of the iterative multiplier against a behavioural model.
module tb_mul_iter_wallace_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic i_valid = 1'b0, i_signed = 1'b0, i_ready = 1'b0;
  logic [31:0] i_num_a = '0, i_num_b = '0;
  logic o_ready, o_valid, o_busy;
  logic [63:0] o_res;
  int errors = 0, checks = 0;
  logic [63:0] sb [$];
`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  mul_iter_wallace_ctrl #(.W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_signed(i_signed),
    .i_num_a(i_num_a), .i_num_b(i_num_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_res(o_res), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'b0, a};
    xb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction
  function automatic int model_lat(input logic [31:0] b, input logic s);
    logic [31:0] m;
    int n;
    m = (s && b[31]) ? -b : b;
    n = 4;
    if (EARLY)
      for (int k = 1; k <= 4; k++)
        if ((m >> (8 * k)) == 0) begin
          n = k;
          break;
        end
    return n + 2;
  endfunction
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    int lat;
    logic [63:0] exp_res;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    chk("ready_idle", {63'b0, o_ready}, 64'd1);
    i_valid = 1'b1; i_num_a = a; i_num_b = b; i_signed = s;
    @(posedge clk); #1;
    i_valid = 1'b0; i_num_a = $urandom; i_num_b = $urandom; i_signed = 1'($urandom);
    chk("ready_busy", {62'b0, o_ready, o_busy}, 64'd1);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(model_lat(b, s)));
    exp_res = sb.size() > 0 ? sb.pop_front() : 64'hx;
    chk("result", o_res, exp_res);
    for (int i = 0; i < hold; i++) begin
      i_valid = 1'(i % 2);
      @(posedge clk); #1;
      chk("hold_res", o_res, exp_res);
      chk("hold_flags", {61'b0, o_valid, o_ready, o_busy}, 64'b101);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("drop_valid", {62'b0, o_valid, o_busy}, 64'd0);
  endtask
  initial begin
    #12;
    chk("rst_flags", {61'b0, o_valid, o_ready, o_busy}, 64'b010);
    chk("rst_res", o_res, 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    chk("const_uu", o_res, 64'hFFFFFFFE00000001);
    run_op(32'h80000000, 32'h80000000, 1'b1, 0);
    chk("const_min", o_res, 64'h4000000000000000);
    run_op(32'hFFFFFFFD, 32'd7, 1'b1, 0);
    chk("const_neg", o_res, 64'hFFFFFFFFFFFFFFEB);
    run_op(32'h12345678, 32'h000000FF, 1'b0, 0);
    run_op(32'h12345678, 32'h0, 1'b1, 0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    run_op(32'h7FFFFFFF, 32'h80000000, 1'b1, 10);
    @(negedge clk);
    i_valid = 1'b1; i_num_a = 32'hDEADBEEF; i_num_b = 32'hFFFFFFFF; i_signed = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("midrst_flags", {61'b0, o_valid, o_ready, o_busy}, 64'b010);
    chk("midrst_res", o_res, 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(32'd5, 32'd6, 1'b0, 0);
    chk("after_rst", o_res, 64'd30);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b;
      int gap;
      a = (n % 7 == 0) ? 32'h80000000 : $urandom;
      b = (n % 5 == 0) ? 32'($urandom_range(0, 70000)) : $urandom;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
      run_op(a, b, 1'($urandom), $urandom_range(0, 3));
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
